// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the round-robin/fixed priority encoder.
package prio_enc_pkg;

    typedef enum logic {FIXED = 1'b0, RR = 1'b1} arb_mode_e;

    // Legacy encoders report the winner counted from the top bit.
    function automatic int enc_idx(input int w, input int n, input int rev);
        return (rev != 0) ? (n - 1 - w) : w;
    endfunction

endpackage

// File: rtl/prio_enc_rr_sva.sv
// Protocol checker bound into every prio_enc_rr instance.
module prio_enc_rr_sva #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input logic             clk,
    input logic             rst,
    input logic             ready,
    input logic [IDX_W-1:0] Y,
    input logic [N-1:0]     gnt,
    input logic             valid
);

    a_gnt_shape: assert property (@(posedge clk) disable iff (!rst)
        valid ? $onehot(gnt) : (gnt == '0));

    // A stalled result must not move until it is taken.
    a_hold: assert property (@(posedge clk) disable iff (!rst)
        (valid && !ready) |=> (valid && $stable(Y) && $stable(gnt)));

endmodule

bind prio_enc_rr prio_enc_rr_sva #(.N(N), .IDX_W(IDX_W)) u_sva (
    .clk(clk), .rst(rst), .ready(ready), .Y(Y), .gnt(gnt), .valid(valid)
);

// File: rtl/prio_find_first.sv
// Combinational lowest-set-bit finder: flag, binary index and one-hot.
module prio_find_first #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    always_comb begin
        found  = |req;
        idx    = '0;
        // Scan downward so the last hit written is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
        onehot = req & (~req + N'(1));
    end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered N-input priority encoder with fixed or round-robin arbitration
// and a valid/ready output stage.
module prio_enc_rr
    import prio_enc_pkg::*;
#(
    parameter int N       = 8,
    parameter int IDX_W   = $clog2(N),
    parameter int REV_IDX = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     D,
    input  logic             mode,
    input  logic             ready,
    output logic [IDX_W-1:0] Y,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    arb_mode_e        arb_mode;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] w_q;
    logic [N-1:0]     mask;
    logic [N-1:0]     masked;
    logic             found_a, found_m;
    logic [IDX_W-1:0] idx_a, idx_m;
    logic [N-1:0]     oh_a, oh_m;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_oh;
    logic             load, accept;

    assign arb_mode = arb_mode_e'(mode);
    // Requests below the pointer lose this round; bits [ptr-1:0] cleared.
    assign mask     = ~((N'(1) << ptr) - N'(1));
    assign masked   = D & mask;

    prio_find_first #(.N(N), .IDX_W(IDX_W)) u_ff_all (
        .req(D), .found(found_a), .idx(idx_a), .onehot(oh_a)
    );

    prio_find_first #(.N(N), .IDX_W(IDX_W)) u_ff_msk (
        .req(masked), .found(found_m), .idx(idx_m), .onehot(oh_m)
    );

    // An empty masked set wraps around to the plain lowest request.
    always_comb begin
        win_idx = idx_a;
        win_oh  = oh_a;
        if (arb_mode == RR && found_m) begin
            win_idx = idx_m;
            win_oh  = oh_m;
        end
    end

    assign load   = !valid || ready;
    assign accept = valid && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            w_q   <= '0;
            Y     <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else begin
            if (accept && arb_mode == RR)
                ptr <= (w_q == IDX_W'(N - 1)) ? '0 : w_q + 1'b1;
            if (load) begin
                if (found_a) begin
                    valid <= 1'b1;
                    w_q   <= win_idx;
                    gnt   <= win_oh;
                    Y     <= IDX_W'(enc_idx(int'(win_idx), N, REV_IDX));
                end else begin
                    valid <= 1'b0;
                    w_q   <= '0;
                    gnt   <= '0;
                    Y     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Scoreboarded bench: two N=8 encoders (both index encodings) plus N=2/5/64 sweep instances.
module tb_prio_enc_rr;

    logic        clk;
    logic        rst;
    logic [63:0] d;
    logic        mode;
    logic        ready;

    logic [2:0]  ya, yb;
    logic [7:0]  ga, gb;
    logic        va, vb;
    logic [0:0]  y2;
    logic [1:0]  g2;
    logic        v2;
    logic [2:0]  y5;
    logic [4:0]  g5;
    logic        v5;
    logic [5:0]  y64;
    logic [63:0] g64;
    logic        v64;

    prio_enc_rr #(.N(8), .REV_IDX(1)) dut_a (
        .clk(clk), .rst(rst), .D(d[7:0]), .mode(mode), .ready(ready),
        .Y(ya), .gnt(ga), .valid(va));
    prio_enc_rr #(.N(8), .REV_IDX(0)) dut_b (
        .clk(clk), .rst(rst), .D(d[7:0]), .mode(mode), .ready(ready),
        .Y(yb), .gnt(gb), .valid(vb));
    prio_enc_rr #(.N(2), .REV_IDX(1)) dut_2 (
        .clk(clk), .rst(rst), .D(d[1:0]), .mode(mode), .ready(ready),
        .Y(y2), .gnt(g2), .valid(v2));
    prio_enc_rr #(.N(5), .REV_IDX(0)) dut_5 (
        .clk(clk), .rst(rst), .D(d[4:0]), .mode(mode), .ready(ready),
        .Y(y5), .gnt(g5), .valid(v5));
    prio_enc_rr #(.N(64), .REV_IDX(1)) dut_64 (
        .clk(clk), .rst(rst), .D(d), .mode(mode), .ready(ready),
        .Y(y64), .gnt(g64), .valid(v64));

    typedef struct packed {
        logic [2:0] ya;
        logic [7:0] ga;
        logic       va;
        logic [2:0] yb;
        logic [7:0] gb;
        logic [2:0] ptr;
    } exp_t;

    logic [2:0] ptr_b;
    exp_t       obs8;
    assign ptr_b = dut_b.ptr;
    assign obs8  = '{ya: ya, ga: ga, va: va, yb: yb, gb: gb, ptr: ptr_b};

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state for the N=8 pair
    logic mval;
    int   mw;
    int   mptr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int pick(input logic [7:0] dv, input logic m, input int p);
        if (m) begin
            for (int j = p; j < 8; j++) if (dv[j]) return j;
        end
        for (int j = 0; j < 8; j++) if (dv[j]) return j;
        return 0;
    endfunction

    task automatic model_reset();
        mval = 1'b0;
        mw   = 0;
        mptr = 0;
        sb.delete();
    endtask

    // Drive one cycle, predict the registered result, pop it after the edge.
    task automatic cycle(input logic [63:0] dv, input logic m, input logic r, output exp_t e);
        logic ld, acc, nval;
        int   nw, nptr;
        exp_t x;
        d = dv; mode = m; ready = r;
        ld   = !mval || r;
        acc  = mval && r;
        nval = mval;
        nw   = mw;
        nptr = (acc && m) ? ((mw == 7) ? 0 : mw + 1) : mptr;
        if (ld) begin
            nval = (dv[7:0] != 8'h00);
            nw   = nval ? pick(dv[7:0], m, mptr) : 0;
        end
        mval = nval; mw = nw; mptr = nptr;
        x.va  = mval;
        x.ya  = mval ? 3'(7 - mw) : 3'd0;
        x.yb  = mval ? 3'(mw) : 3'd0;
        x.ga  = mval ? 8'(1 << mw) : 8'h00;
        x.gb  = x.ga;
        x.ptr = 3'(mptr);
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        exp_t e;
        #3;
        checks++;
        if ({ya, ga, va, yb, gb, vb, ptr_b} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0", {ya, ga, va, yb, gb, vb, ptr_b});
        end
        @(posedge clk); #1; rst = 1'b1;
        cycle(64'h00, 1'b0, 1'b1, e);
        checks++;
        if (obs8 !== e || va !== 1'b0) begin
            errors++; $display("FAIL reset_release_empty: got %h required %h", obs8, e);
        end
        cycle(64'h10, 1'b1, 1'b1, e);
        cycle(64'h10, 1'b1, 1'b1, e);
        cycle(64'h10, 1'b1, 1'b0, e);
        checks++;
        if (obs8 !== e || ptr_b !== 3'd5 || va !== 1'b1) begin
            errors++; $display("FAIL reset_prep: got %h required %h", obs8, e);
        end
        #3; rst = 1'b0; #1;
        checks++;
        if ({ya, ga, va, yb, gb, vb, ptr_b} !== 26'd0) begin
            errors++;
            $display("FAIL reset_async: got %h required 0", {ya, ga, va, yb, gb, vb, ptr_b});
        end
        model_reset();
        @(posedge clk); #1; rst = 1'b1;
        cycle(64'h00, 1'b0, 1'b1, e);
        checks++;
        if (obs8 !== e || va !== 1'b0) begin
            errors++; $display("FAIL reset_d0_invalid: got %h required %h", obs8, e);
        end
        cycle(64'h11, 1'b1, 1'b1, e);
        checks++;
        if (obs8 !== e || yb !== 3'd0) begin
            errors++; $display("FAIL reset_cold_ptr: got %h required %h", obs8, e);
        end
    endtask

    task automatic test_fixed();
        exp_t e;
        cycle(64'h64, 1'b0, 1'b1, e);
        checks++;
        if (obs8 !== e || ya !== 3'd5 || ga !== 8'h04 || va !== 1'b1) begin
            errors++; $display("FAIL fixed_0x64: got %h required %h", obs8, e);
        end
        cycle(64'h80, 1'b0, 1'b1, e);
        checks++;
        if (obs8 !== e || ya !== 3'd0 || yb !== 3'd7) begin
            errors++; $display("FAIL fixed_0x80: got %h required %h", obs8, e);
        end
    endtask

    task automatic test_rr_rotation();
        exp_t e;
        int   ys[4] = '{0, 3, 7, 0};
        int   ps[4] = '{1, 4, 0, 1};
        cycle(64'h00, 1'b1, 1'b1, e);
        checks++;
        if (obs8 !== e || ptr_b !== 3'd0) begin
            errors++; $display("FAIL rr_start: got %h required %h", obs8, e);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(64'h89, 1'b1, 1'b1, e);
            checks++;
            if (obs8 !== e || yb !== 3'(ys[k])) begin
                errors++; $display("FAIL rr_grant_%0d: got %h required %h", k, obs8, e);
            end
            cycle(64'h00, 1'b1, 1'b1, e);
            checks++;
            if (obs8 !== e || ptr_b !== 3'(ps[k])) begin
                errors++; $display("FAIL rr_ptr_%0d: got %h required %h", k, obs8, e);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [63:0] ds[3] = '{64'h02, 64'h10, 64'h00};
        cycle(64'h02, 1'b0, 1'b1, e);
        for (int k = 0; k < 3; k++) begin
            cycle(ds[k], 1'b0, 1'b0, e);
            checks++;
            if (obs8 !== e || yb !== 3'd1 || gb !== 8'h02 || vb !== 1'b1) begin
                errors++; $display("FAIL bp_hold_%0d: got %h required %h", k, obs8, e);
            end
        end
        cycle(64'h00, 1'b0, 1'b1, e);
        checks++;
        if (obs8 !== e || vb !== 1'b0) begin
            errors++; $display("FAIL bp_release_empty: got %h required %h", obs8, e);
        end
        cycle(64'h08, 1'b0, 1'b1, e);
        cycle(64'h10, 1'b0, 1'b0, e);
        cycle(64'h10, 1'b0, 1'b1, e);
        checks++;
        if (obs8 !== e || yb !== 3'd4 || ptr_b !== 3'd1) begin
            errors++; $display("FAIL bp_release_load: got %h required %h", obs8, e);
        end
    endtask

    task automatic test_wrap_mode();
        exp_t e;
        cycle(64'h20, 1'b1, 1'b1, e);
        cycle(64'h00, 1'b1, 1'b1, e);
        checks++;
        if (obs8 !== e || ptr_b !== 3'd6) begin
            errors++; $display("FAIL wrap_ptr6: got %h required %h", obs8, e);
        end
        cycle(64'h01, 1'b1, 1'b1, e);
        checks++;
        if (obs8 !== e || yb !== 3'd0 || vb !== 1'b1) begin
            errors++; $display("FAIL wrap_grant: got %h required %h", obs8, e);
        end
        cycle(64'h00, 1'b1, 1'b1, e);
        checks++;
        if (obs8 !== e || ptr_b !== 3'd1) begin
            errors++; $display("FAIL wrap_ptr1: got %h required %h", obs8, e);
        end
        cycle(64'h06, 1'b0, 1'b1, e);
        checks++;
        if (obs8 !== e || yb !== 3'd1 || ptr_b !== 3'd1) begin
            errors++; $display("FAIL mode_fixed_grant: got %h required %h", obs8, e);
        end
        cycle(64'h00, 1'b0, 1'b1, e);
        checks++;
        if (obs8 !== e || ptr_b !== 3'd1) begin
            errors++; $display("FAIL mode_fixed_ptr: got %h required %h", obs8, e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [63:0] dv;
        logic        m, r;
        for (int k = 0; k < 28; k++) begin
            if (k < 4)       begin dv = 64'h89; m = 1'b1; r = 1'b1; end
            else if (k < 7)  begin dv = 64'hff; m = 1'b1; r = 1'b1; end
            else if (k < 9)  begin dv = 64'h5a; m = 1'b0; r = 1'b1; end
            else if (k < 12) begin dv = 64'h24; m = 1'b1; r = 1'b1; end
            else begin
                dv = 64'($urandom_range(0, 255));
                m  = 1'($urandom_range(0, 1));
                r  = 1'($urandom_range(0, 1));
            end
            cycle(dv, m, r, e);
            checks++;
            if (obs8 !== e) begin
                errors++; $display("FAIL b2b_%0d: got %h required %h", k, obs8, e);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            cycle(64'd1 << i, 1'((i % 2) == 1), 1'b1, e);
            checks++;
            if (obs8 !== e) begin
                errors++; $display("FAIL sweep8_%0d: got %h required %h", i, obs8, e);
            end
            checks++;
            if ({y2, g2, v2} !== ((i < 2) ? {1'(1 - i), 2'(1 << i), 1'b1} : 4'b0)) begin
                errors++; $display("FAIL sweep2_%0d: got %h", i, {y2, g2, v2});
            end
            checks++;
            if ({y5, g5, v5} !== ((i < 5) ? {3'(i), 5'(1 << i), 1'b1} : 9'b0)
                || (v5 && y5 >= 3'd5)) begin
                errors++; $display("FAIL sweep5_%0d: got %h", i, {y5, g5, v5});
            end
            checks++;
            if ({y64, g64, v64} !== {6'(63 - i), 64'd1 << i, 1'b1}) begin
                errors++; $display("FAIL sweep64_%0d: got y=%0d v=%b gnt=%h", i, y64, v64, g64);
            end
        end
    endtask

    initial begin
        rst = 1'b1; d = '0; mode = 1'b0; ready = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_backpressure();
        test_wrap_mode();
        test_back_to_back();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_enc_rr.md
# prio_enc_rr

Parametrised registered priority encoder with two arbitration modes (fixed-priority and round-robin) and a valid/ready output handshake. It generalises the team's 4-bit registered priority encoder to N request lines. It adds a rotating-priority pointer and output back-pressure so it can sit directly in front of a shared resource as a request arbiter.

## Interface
Parameters:
- N, 8, number of request lines; legal range 2..64.
- IDX_W, $clog2(N), width of the encoded index output.
- REV_IDX, 1, index encoding; 1 gives Y = N-1-i (legacy encoding), 0 gives Y = i.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- D  in  N  request vector; bit i is request i.
- mode  in  1  arbitration mode; 0 = FIXED (bit 0 highest priority), 1 = RR (round-robin).
- ready  in  1  consumer accepts the current result.
- Y  out  IDX_W  encoded index of the granted request.
- gnt  out  N  one-hot grant of the same request; all zeros when valid = 0.
- valid  out  1  Y and gnt hold a live result.

## Operation
- Load condition: load = !valid || ready. Loads happen only on cycles where load = 1.
- On a load with D != 0:
  - Select winner index w (rules below).
  - Register valid = 1, gnt = one-hot(w), Y = REV_IDX ? N-1-w : w.
- On a load with D == 0: register valid = 0, Y = 0, gnt = 0.
- When load = 0 (valid = 1 and ready = 0): Y, gnt and valid hold their values and D is ignored, even if the request has dropped.
- FIXED winner: lowest set index of D.
- RR winner: uses priority pointer ptr (IDX_W bits).
  - masked = D with bits [ptr-1:0] cleared.
  - If masked != 0, winner = lowest set index of masked.
  - Otherwise, winner = lowest set index of D (wrap-around).
- Pointer update: on an accept (valid && ready) while mode = 1 at that edge, ptr <= (w == N-1) ? 0 : w+1, where w is the index currently presented.
  - ptr is unchanged in FIXED mode.
  - ptr is unchanged by loads that are not accepts.
- Mode changes take effect on the next load. A result already held is not re-evaluated.
- Reset (asynchronous assertion, at any time including mid-handshake):
  - Y = 0, gnt = 0, valid = 0, ptr = 0.
  - Any held result is discarded.
  - The first load after rst deasserts behaves like a cold start.

## Timing
- Latency: D sampled at edge k appears on Y/gnt/valid after edge k (registered, 1 cycle).
- Throughput: one result per cycle while ready = 1.
- Accept and reload on the same edge: the old result is consumed and the new D is encoded in the same cycle, with no bubble.
- Winner selection uses the pre-update ptr. For example, if the accept at edge k moves ptr, the load at edge k still uses the old ptr.
- Back-pressure: with ready = 0, outputs are stable for every cycle that valid = 1.
- Reset release: the first edge after rst goes high may load.

## Structure
- Package prio_enc_pkg:
  - typedef enum logic {FIXED = 1'b0, RR = 1'b1} arb_mode_e.
  - Helper function for the index transform (REV_IDX).
- Sub-module prio_find_first: combinational lowest-set-bit finder, parameter N.
  - Outputs: found, idx, onehot.
  - Instantiated twice in RR (masked and unmasked). The FIXED path reuses the unmasked instance.
- Top level contents: the load/accept logic, the ptr register and the output registers.
- The SVA checker is a separate bound module, in the style of the existing encoder checker.

## Test plan
- Reset: drive rst = 0 mid-stream with valid = 1 -> immediately Y = 0, gnt = 0, valid = 0. After release, D = 8'h00 -> valid stays 0.
- FIXED, N = 8, REV_IDX = 1, ready = 1: D = 8'b0110_0100 -> next cycle Y = 5, gnt = 8'h04, valid = 1. D = 8'h80 -> Y = 0.
- RR rotation, REV_IDX = 0, ready = 1, D held at 8'b1000_1001 -> successive Y = 0, 3, 7, 0 and ptr = 1, 4, 0, 1.
- Back-pressure: ready = 0 for 3 cycles while D changes 8'h02 -> 8'h10 -> 8'h00.
  - Y/gnt stay at index 1 and valid stays 1.
  - Raising ready loads the current D on the same edge.
- Wrap and mode switch:
  - ptr = 6, D = 8'h01, mode = RR -> Y = 0 (wrap), and the accept sets ptr = 1.
  - Then mode = FIXED with D = 8'h06 -> Y = 1 and ptr remains 1.
- Parameter sweep N = 2, 5, 64: a single-bit D at each index i -> Y per REV_IDX and gnt = 1 << i. An out-of-range index never appears.
